// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word handshake plus serial line bundle.
// The master side offers words; the slave side shifts them out.
interface serial_word_tx_if #(
  parameter int L = 24
);
  logic         in_valid;
  logic [L-1:0] in_data;
  logic         in_ready;
  logic         sclk;
  logic         sdo;
  logic         fs;
  logic         busy;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  sclk,
    input  sdo,
    input  fs,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output sclk,
    output sdo,
    output fs,
    output busy
  );
endinterface

// File: rtl/serial_word_tx.sv
// serial_word_tx: MSB-first word serializer with bit clock and frame sync.
// Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit per word.
module serial_word_tx #(
  parameter int L   = 24,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_word_tx_if.slave tx
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(L + 1);

  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DHALF = DW'(DIV / 2);
  localparam logic [BW-1:0] BLAST = BW'(L - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [L-1:0]  sr_q, sr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          sdo_q, sdo_d;
  logic          fs_q, fs_d;
  logic          busy_q, busy_d;
  logic          wrap;
  logic          accept;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign wrap   = (div_q == DLAST);
  assign accept = (state_q == IDLE) && tx.in_valid;

  // Next-state: handshake capture, bit timing and word sequencing
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    div_d   = div_q;
`ifdef SERIAL_WORD_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sr_d    = tx.in_data;
          bit_d   = '0;
          div_d   = '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
          par_d   = ^tx.in_data;
`endif
        end
      end
      SHIFT: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
          sr_d  = {sr_q[L-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BLAST) begin
`ifdef SERIAL_WORD_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = GAP;
`endif
          end
        end
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      PARITY: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) state_d = GAP;
      end
`endif
      GAP: begin
        div_d = wrap ? '0 : div_q + 1'b1;
        if (wrap) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from next state so the line pins stay registered
  always_comb begin
    sclk_d = 1'b0;
    sdo_d  = 1'b0;
    fs_d   = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (1'b1)
      (state_d == SHIFT): begin
        sdo_d  = sr_d[L-1];
        sclk_d = (div_d >= DHALF);
        fs_d   = (bit_d == '0);
      end
`ifdef SERIAL_WORD_TX_PARITY_EN
      (state_d == PARITY): begin
        sdo_d  = par_d;
        sclk_d = (div_d >= DHALF);
      end
`endif
      default: begin
      end
    endcase
  end

  // State and datapath registers; reset aborts any word in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
`ifdef SERIAL_WORD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Registered serial line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 1'b0;
      sdo_q  <= 1'b0;
      fs_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
      sdo_q  <= sdo_d;
      fs_q   <= fs_d;
      busy_q <= busy_d;
    end
  end

  assign tx.in_ready = (state_q == IDLE);
  assign tx.sclk     = sclk_q;
  assign tx.sdo      = sdo_q;
  assign tx.fs       = fs_q;
  assign tx.busy     = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed vectors for two serial_word_tx builds.
// Instance a: L=24 DIV=4; instance b: L=8 DIV=3.
module tb_serial_word_tx;
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int P     = 1;
  localparam int PER_A = 104;
  localparam int PER_B = 30;
  localparam int B2B   = 105;
`else
  localparam int P     = 0;
  localparam int PER_A = 100;
  localparam int PER_B = 27;
  localparam int B2B   = 101;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_word_tx_if #(.L(24)) ifa ();
  serial_word_tx_if #(.L(8))  ifb ();

  serial_word_tx #(.L(24), .DIV(4)) dut_a (
    .clk(clk),
    .rst(rst),
    .tx (ifa)
  );

  serial_word_tx #(.L(8), .DIV(3)) dut_b (
    .clk(clk),
    .rst(rst),
    .tx (ifb)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    logic ready;
    logic sclk;
    logic sdo;
    logic fs;
    logic busy;
  } smp_t;

  typedef struct {
    bit          sel;
    logic [23:0] d;
    logic [23:0] eb;
    logic        ep;
    int          per;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic smp_t smp(input bit sel);
    smp_t s;
    if (sel) begin
      s.ready = ifb.in_ready;
      s.sclk  = ifb.sclk;
      s.sdo   = ifb.sdo;
      s.fs    = ifb.fs;
      s.busy  = ifb.busy;
    end else begin
      s.ready = ifa.in_ready;
      s.sclk  = ifa.sclk;
      s.sdo   = ifa.sdo;
      s.fs    = ifa.fs;
      s.busy  = ifa.busy;
    end
    return s;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [23:0] d);
    if (sel) begin
      ifb.in_valid = v;
      ifb.in_data  = d[7:0];
    end else begin
      ifa.in_valid = v;
      ifa.in_data  = d;
    end
  endtask

  task automatic wait_idle(input bit sel, input string nm);
    smp_t s;
    int   n;
    n = 0;
    @(negedge clk);
    s = smp(sel);
    while (!s.ready && n < 500) begin
      @(negedge clk);
      s = smp(sel);
      n++;
    end
    chk({nm, " idle"}, 32'(s.ready), 32'd1);
  endtask

  task automatic send_word(input bit sel, input logic [23:0] d,
                           input logic [23:0] eb, input logic ep,
                           input int per, input string nm);
    int          n;
    int          dv;
    int          k;
    int          rises;
    int          fsc;
    int          busy_bad;
    int          stab_bad;
    int          hi_cnt;
    bit          done;
    logic        fs0;
    logic        gpar;
    logic [3:0]  first;
    logic [23:0] got;
    smp_t        s;
    smp_t        p;
    n = sel ? 8 : 24;
    dv = sel ? 3 : 4;
    rises = 0; fsc = 0; busy_bad = 0; stab_bad = 0; hi_cnt = 0;
    done = 1'b0; fs0 = 1'b0; gpar = 1'b0; first = '0; got = '0;
    p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    s = p;
    wait_idle(sel, nm);
    drive(sel, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, ~d);
    for (k = 0; k < 400; k++) begin
      s = smp(sel);
      if (s.ready) begin
        done = 1'b1;
        break;
      end
      if (k < 4) first[k] = s.sclk;
      if (k == 0) fs0 = s.fs;
      if (s.sclk && !p.sclk) begin
        if (rises < n) got = {got[22:0], s.sdo};
        else gpar = s.sdo;
        rises++;
      end
      if (p.sclk && s.sclk && (s.sdo !== p.sdo || s.fs !== p.fs))
        stab_bad++;
      if (s.fs) fsc++;
      if (s.busy !== 1'b1) busy_bad++;
      if (s.sclk) hi_cnt++;
      p = s;
      @(negedge clk);
    end
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " period"}, 32'(k), 32'(per));
    chk({nm, " bits"}, 32'(got), 32'(eb));
    chk({nm, " rises"}, 32'(rises), 32'(n + P));
`ifdef SERIAL_WORD_TX_PARITY_EN
    chk({nm, " parity"}, 32'(gpar), 32'(ep));
`else
    chk({nm, " no parity"}, 32'(ep & 1'b0), 32'(gpar));
`endif
    chk({nm, " fs first"}, 32'(fs0), 32'd1);
    chk({nm, " fs len"}, 32'(fsc), 32'(dv));
    chk({nm, " busy"}, 32'(busy_bad), 32'd0);
    chk({nm, " stable"}, 32'(stab_bad), 32'd0);
    chk({nm, " busy end"}, 32'(s.busy), 32'd0);
    chk({nm, " sclk shape"}, 32'(first), sel ? 32'h6 : 32'hC);
    chk({nm, " sclk high"}, 32'(hi_cnt), 32'((dv - dv / 2) * (n + P)));
  endtask

  vec_t tv[5];

  initial begin
    smp_t s;
    smp_t p;
    int   fsq[$];
    logic b2b[64];
    int   nb;
    int   gap;
    logic [23:0] w1;
    logic [23:0] w2;

    tv[0] = '{1'b0, 24'hA5C3F0, 24'hA5C3F0, 1'b0, PER_A};
    tv[1] = '{1'b0, 24'h000007, 24'h000007, 1'b1, PER_A};
    tv[2] = '{1'b0, 24'h800001, 24'h800001, 1'b0, PER_A};
    tv[3] = '{1'b1, 24'h00005A, 24'h00005A, 1'b0, PER_B};
    tv[4] = '{1'b1, 24'h000001, 24'h000001, 1'b1, PER_B};

    rst = 1'b1;
    drive(1'b0, 1'b1, 24'hFFFFFF);
    drive(1'b1, 1'b1, 24'hFFFFFF);
    repeat (3) @(negedge clk);
    s = smp(1'b0);
    chk("rst sclk", 32'(s.sclk), 32'd0);
    chk("rst sdo", 32'(s.sdo), 32'd0);
    chk("rst fs", 32'(s.fs), 32'd0);
    chk("rst busy", 32'(s.busy), 32'd0);
    s = smp(1'b1);
    chk("rst b outs", 32'({s.sclk, s.sdo, s.fs, s.busy}), 32'd0);
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 24'h0);
    rst = 1'b0;
    @(negedge clk);
    s = smp(1'b0);
    chk("rel ready", 32'(s.ready), 32'd1);
    chk("rel no capture", 32'(s.busy), 32'd0);

    for (int i = 0; i < 5; i++)
      send_word(tv[i].sel, tv[i].d, tv[i].eb, tv[i].ep, tv[i].per,
                $sformatf("vec%0d", i));

    wait_idle(1'b0, "b2b");
    drive(1'b0, 1'b1, 24'h000001);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 24'h800000);
    nb = 0;
    p = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 230; k++) begin
      s = smp(1'b0);
      if (s.fs && !p.fs) fsq.push_back(k);
      if (s.sclk && !p.sclk) begin
        if (nb < 64) b2b[nb] = s.sdo;
        nb++;
      end
      if (fsq.size() >= 2) drive(1'b0, 1'b0, 24'h0);
      p = s;
      @(negedge clk);
    end
    chk("b2b fs count", 32'(fsq.size()), 32'd2);
    gap = (fsq.size() >= 2) ? fsq[1] - fsq[0] : -1;
    chk("b2b fs gap", 32'(gap), 32'(B2B));
    chk("b2b rises", 32'(nb), 32'(2 * (24 + P)));
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < 24; i++) begin
      w1 = {w1[22:0], b2b[i]};
      w2 = {w2[22:0], b2b[24 + P + i]};
    end
    chk("b2b word1", 32'(w1), 32'h000001);
    chk("b2b word2", 32'(w2), 32'h800000);

    wait_idle(1'b0, "abort");
    drive(1'b0, 1'b1, 24'h3FFFFF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 24'h0);
    repeat (42) @(negedge clk);
    s = smp(1'b0);
    chk("abort pre busy", 32'(s.busy), 32'd1);
    chk("abort pre sdo", 32'(s.sdo), 32'd1);
    chk("abort pre sclk", 32'(s.sclk), 32'd1);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b1, 24'h123456);
    #1;
    s = smp(1'b0);
    chk("abort outs", 32'({s.sclk, s.sdo, s.fs, s.busy}), 32'd0);
    chk("abort ready", 32'(s.ready), 32'd1);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b0, 24'h0);
    rst = 1'b0;
    @(negedge clk);
    s = smp(1'b0);
    chk("abort no resume", 32'(s.busy), 32'd0);
    send_word(1'b0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, PER_A, "after abort");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

- Parallel-to-serial transmitter that accepts one L-bit word per valid/ready handshake and shifts it out MSB-first.
- Drives a locally generated bit clock and a frame-sync pulse, for an off-chip or peer serial receiver (e.g. 24-bit audio/sample links).
- Sits downstream of the block's holding registers: those registers write words in, this block reads them out onto the serial line.

## Interface
Parameters:
- L, 24, word width in bits (≥2).
- DIV, 4, clk cycles per serial bit (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream has a word on in_data.
- in_data  in  L  word to transmit.
- in_ready  out  1  block can accept a word this cycle.
- sclk  out  1  serial bit clock; receiver samples sdo on its rising edge.
- sdo  out  1  serial data, MSB first.
- fs  out  1  frame sync; high for the whole first bit period (MSB) of each word.
- busy  out  1  high while a word is in flight (SHIFT, PARITY or GAP).

## Operation
- FSM states: IDLE, SHIFT, PARITY (only when compiled in), GAP.
- Reset state is IDLE.
- Reset values: sclk=0, sdo=0, fs=0, busy=0. Shift register, bit counter and divider counter are all 0.
- **IDLE:**
  - in_ready=1, combinational from state.
  - Handshakes are ignored while rst=1.
  - On a clk edge with in_valid=1 and in_ready=1: capture in_data into the shift register, clear the bit and divider counters, go to SHIFT.
- **SHIFT:**
  - in_ready=0, busy=1.
  - Each bit is held for exactly DIV clk cycles. sdo = current MSB of the shift register.
  - sclk=0 for the first floor(DIV/2) cycles of the bit, then 1 for the remainder.
  - fs=1 during bit 0 only.
  - At the end of the bit period: shift left by one and increment the bit counter.
  - After bit L-1: go to PARITY if enabled, else GAP.
- **PARITY:** one bit period carrying the parity bit; sclk uses the same pattern as a data bit; fs=0.
- **GAP:**
  - One bit period with sdo=0, sclk=0, fs=0, busy=1.
  - Then go to IDLE; busy drops in the same cycle in_ready rises.
- in_data and in_valid are don't-care outside the accepting edge; the captured word is immune to later changes.
- The divider counter is log2(DIV) bits wide and wraps from DIV-1 to 0. The bit counter is ceil(log2(L+1)) bits wide.
- **rst asserted mid-word:** the transfer aborts immediately (asynchronously).
  - All outputs go to their reset values.
  - No partial word is resumed after reset; the next word starts from a fresh handshake.

## Timing
- sclk, sdo, fs and busy are registered outputs.
- The first SHIFT cycle (MSB on sdo, fs=1, busy=1) appears on the clk edge following the accepting edge.
- Word period, accepting edge to in_ready=1 again: (L+1)·DIV cycles, or (L+2)·DIV with parity.
- Back-to-back: if in_valid is held high, the next word is accepted on the first IDLE cycle. Throughput is then one word per (L+1)·DIV+1 cycles, or (L+2)·DIV+1 with parity.
- sdo and fs change only at bit-period boundaries, i.e. while sclk is low. This gives at least floor(DIV/2) cycles of setup before each sclk rising edge.

## Configuration
- **Macro: SERIAL_WORD_TX_PARITY_EN.**
- **Defined:**
  - The PARITY state is present.
  - One extra bit is sent after the LSB: the even-parity bit, i.e. the XOR of all L captured bits.
  - Word period becomes (L+2)·DIV.
- **Undefined:**
  - The PARITY state and the XOR logic are absent.
  - GAP follows the LSB directly.
  - Word period is (L+1)·DIV.

## Test plan
- **Reset values:** assert rst with in_valid=1 -> sclk=sdo=fs=busy=0 and no capture. Release rst -> in_ready=1 on the next cycle.
- **Single word**, L=24, DIV=4, in_data=24'hA5C3F0, parity off:
  - sdo bits sample 1010_0101_1100_0011_1111_0000 on successive sclk rising edges.
  - fs is high for the first 4 cycles only.
  - in_ready returns to 1 exactly 100 cycles after the accepting edge.
- **Back-to-back:** in_valid held high with words 24'h000001 then 24'h800000 -> second fs pulse starts 101 cycles after the first. Each LSB/MSB lands on the correct sclk edge.
- **Parity on**, in_data=24'h000007 -> a 25th bit of 1 follows the LSB. in_ready returns after 104 cycles.
- **Reset mid-word:**
  - Assert rst asynchronously during bit 10 -> outputs go to 0 within the same cycle.
  - After release, a new word 24'hFFFFFF transmits fully with fs on its first bit.
- **Odd divider**, DIV=3, L=8, in_data=8'h5A:
  - Each bit lasts 3 cycles with sclk low 1, high 2.
  - Changing in_data after acceptance does not alter the bits sent.
